// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: runs one single-word bus load/store per EX/MEM entry,
// flags misaligned accesses, and stalls the pipeline until the transfer is done.
module mem_access_ctrl #(
  parameter int WORD_ADDR_W = 30,
  parameter int WORD_DATA_W = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_OP_W    = 2,
  parameter int CTRL_OP_W   = 2,
  parameter int EXP_W       = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] ex_pc,
  input  logic                   ex_en,
  input  logic                   ex_br_flag,
  input  logic [MEM_OP_W-1:0]    ex_mem_op,
  input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
  input  logic [CTRL_OP_W-1:0]   ex_ctrl_op,
  input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
  input  logic                   ex_gpr_we_,
  input  logic [EXP_W-1:0]       ex_exp_code,
  input  logic [WORD_DATA_W-1:0] ex_out,
  output logic                   bus_req,
  input  logic                   bus_grnt,
  output logic                   bus_as,
  output logic                   bus_rw,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy,
  output logic                   busy,
  output logic [WORD_ADDR_W-1:0] mem_pc,
  output logic                   mem_en,
  output logic                   mem_br_flag,
  output logic [CTRL_OP_W-1:0]   mem_ctrl_op,
  output logic [REG_ADDR_W-1:0]  mem_dst_addr,
  output logic                   mem_gpr_we_,
  output logic [EXP_W-1:0]       mem_exp_code,
  output logic [WORD_DATA_W-1:0] mem_out
);

  localparam logic [MEM_OP_W-1:0] OP_LDW         = MEM_OP_W'(1);
  localparam logic [MEM_OP_W-1:0] OP_STW         = MEM_OP_W'(2);
  localparam logic [EXP_W-1:0]    EXP_MISS_ALIGN = EXP_W'(4);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, HOLD} state_t;

  state_t                 state_q, state_d;
  logic                   as_q, as_d;
  logic                   done_q, done_d;
  logic                   flushed_q, flushed_d;
  logic [WORD_DATA_W-1:0] rd_buf_q, rd_buf_d;

  logic [WORD_ADDR_W-1:0] mem_pc_q, mem_pc_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_br_flag_q, mem_br_flag_d;
  logic [CTRL_OP_W-1:0]   mem_ctrl_op_q, mem_ctrl_op_d;
  logic [REG_ADDR_W-1:0]  mem_dst_addr_q, mem_dst_addr_d;
  logic                   mem_gpr_we_q, mem_gpr_we_d;
  logic [EXP_W-1:0]       mem_exp_code_q, mem_exp_code_d;
  logic [WORD_DATA_W-1:0] mem_out_q, mem_out_d;

  logic is_mem_op, no_exp, aligned, access, miss;
  logic busy_c, bus_req_c, bus_drive, rdy_done, rd_latch, wb_en, kill;
  logic [WORD_DATA_W-1:0] load_data;

  assign is_mem_op = ex_en & ((ex_mem_op == OP_LDW) | (ex_mem_op == OP_STW));
  assign no_exp    = (ex_exp_code == '0);
  assign aligned   = (ex_out[1:0] == 2'b00);
  assign access    = is_mem_op & no_exp & aligned & ~flush;
  assign miss      = is_mem_op & no_exp & ~aligned;

  always_comb begin
    state_d   = state_q;
    as_d      = 1'b0;
    flushed_d = flushed_q;
    busy_c    = 1'b0;
    bus_req_c = 1'b0;
    bus_drive = 1'b0;
    rdy_done  = 1'b0;
    rd_latch  = 1'b0;
    case (state_q)
      IDLE: begin
        flushed_d = 1'b0;
        if (access && !done_q) begin
          busy_c  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        bus_drive = 1'b1;
        // A flush before grant simply withdraws the request.
        if (flush) begin
          state_d = IDLE;
        end else begin
          busy_c    = 1'b1;
          bus_req_c = 1'b1;
          if (bus_grnt) begin
            state_d = ACCESS;
            as_d    = 1'b1;
          end
        end
      end
      ACCESS: begin
        bus_drive = 1'b1;
        bus_req_c = 1'b1;
        if (flush) flushed_d = 1'b1;
        if (bus_rdy) begin
          rdy_done  = 1'b1;
          rd_latch  = ~(flush | flushed_q);
          flushed_d = 1'b0;
          state_d   = (stall && !(flush || flushed_q)) ? HOLD : IDLE;
        end else begin
          busy_c = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush seen at any point during the transfer turns its result into a bubble.
  assign kill      = flush | ((state_q == ACCESS) & flushed_q);
  assign wb_en     = ~stall & ~busy_c;
  assign load_data = (state_q == ACCESS) ? bus_rd_data : rd_buf_q;
  assign rd_buf_d  = rd_latch ? bus_rd_data : rd_buf_q;
  assign done_d    = wb_en ? 1'b0 : (rdy_done ? 1'b1 : done_q);

  always_comb begin
    mem_pc_d       = '0;
    mem_en_d       = 1'b0;
    mem_br_flag_d  = 1'b0;
    mem_ctrl_op_d  = '0;
    mem_dst_addr_d = '0;
    mem_gpr_we_d   = 1'b1;
    mem_exp_code_d = '0;
    mem_out_d      = '0;
    if (!kill) begin
      if (miss) begin
        mem_pc_d       = ex_pc;
        mem_en_d       = ex_en;
        mem_br_flag_d  = ex_br_flag;
        mem_exp_code_d = EXP_MISS_ALIGN;
      end else begin
        mem_pc_d       = ex_pc;
        mem_en_d       = ex_en;
        mem_br_flag_d  = ex_br_flag;
        mem_ctrl_op_d  = ex_ctrl_op;
        mem_dst_addr_d = ex_dst_addr;
        mem_gpr_we_d   = ex_gpr_we_;
        mem_exp_code_d = ex_exp_code;
        mem_out_d      = (ex_mem_op == OP_LDW) ? load_data : ex_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      as_q           <= 1'b0;
      done_q         <= 1'b0;
      flushed_q      <= 1'b0;
      rd_buf_q       <= '0;
      mem_pc_q       <= '0;
      mem_en_q       <= 1'b0;
      mem_br_flag_q  <= 1'b0;
      mem_ctrl_op_q  <= '0;
      mem_dst_addr_q <= '0;
      mem_gpr_we_q   <= 1'b1;
      mem_exp_code_q <= '0;
      mem_out_q      <= '0;
    end else begin
      state_q   <= state_d;
      as_q      <= as_d;
      done_q    <= done_d;
      flushed_q <= flushed_d;
      rd_buf_q  <= rd_buf_d;
      if (wb_en) begin
        mem_pc_q       <= mem_pc_d;
        mem_en_q       <= mem_en_d;
        mem_br_flag_q  <= mem_br_flag_d;
        mem_ctrl_op_q  <= mem_ctrl_op_d;
        mem_dst_addr_q <= mem_dst_addr_d;
        mem_gpr_we_q   <= mem_gpr_we_d;
        mem_exp_code_q <= mem_exp_code_d;
        mem_out_q      <= mem_out_d;
      end
    end
  end

  assign busy        = busy_c & ~reset;
  assign bus_req     = bus_req_c;
  assign bus_as      = as_q;
  assign bus_rw      = bus_drive & (ex_mem_op == OP_LDW);
  assign bus_addr    = bus_drive ? ex_out[WORD_DATA_W-1:2] : '0;
  assign bus_wr_data = bus_drive ? ex_mem_wr_data : '0;

  assign mem_pc       = mem_pc_q;
  assign mem_en       = mem_en_q;
  assign mem_br_flag  = mem_br_flag_q;
  assign mem_ctrl_op  = mem_ctrl_op_q;
  assign mem_dst_addr = mem_dst_addr_q;
  assign mem_gpr_we_  = mem_gpr_we_q;
  assign mem_exp_code = mem_exp_code_q;
  assign mem_out      = mem_out_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register.
- Decodes ex_mem_op and ex_out, runs a single-word bus transaction (request/grant/strobe/ready), and raises a misalignment exception when needed.
- Asserts busy to stall the pipeline while a transaction is outstanding, then updates the MEM/WB pipeline register.
- Sits between the EX/MEM register, the bus interface and the WB stage.

Parameters:
- WORD_ADDR_W, 30, word address width (byte address = {addr, 2'b00}).
- WORD_DATA_W, 32, data width.
- REG_ADDR_W, 5, GPR address width.
- MEM_OP_W, 2, memory-op width; encodings: 0 NOP, 1 LDW, 2 STW, 3 reserved (treated as NOP).
- CTRL_OP_W, 2, control-op width; 0 = NOP.
- EXP_W, 3, exception-code width; 0 NO_EXP, 4 MISS_ALIGN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high; all state updates on the rising edge of clk
- stall  in  1  global pipeline stall; the MEM/WB register holds while 1
- flush  in  1  flush MEM/WB to a bubble
- ex_pc  in  WORD_ADDR_W  PC
- ex_en  in  1  EX/MEM entry valid
- ex_br_flag  in  1  branch flag
- ex_mem_op  in  MEM_OP_W  memory op
- ex_mem_wr_data  in  WORD_DATA_W  store data
- ex_ctrl_op  in  CTRL_OP_W  control op
- ex_dst_addr  in  REG_ADDR_W  GPR destination
- ex_gpr_we_  in  1  GPR write enable, active-low
- ex_exp_code  in  EXP_W  upstream exception
- ex_out  in  WORD_DATA_W  ALU result / byte address
- bus_req  out  1  bus request
- bus_grnt  in  1  bus grant
- bus_as  out  1  address strobe, one cycle
- bus_rw  out  1  1 = read, 0 = write
- bus_addr  out  WORD_ADDR_W  word address
- bus_wr_data  out  WORD_DATA_W  write data
- bus_rd_data  in  WORD_DATA_W  read data
- bus_rdy  in  1  transfer complete
- busy  out  1  stall request to the pipeline controller
- mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out  out  same widths as ex_*  MEM/WB register outputs

Behaviour:
- Access qualification:
  - access = ex_en & (op==LDW | op==STW) & ex_exp_code==0 & ex_out[1:0]==0 & !flush.
  - miss = ex_en & (LDW|STW) & ex_exp_code==0 & ex_out[1:0]!=0.
- Bus outputs:
  - bus_addr = ex_out[WORD_DATA_W-1:2].
  - bus_wr_data = ex_mem_wr_data.
  - bus_rw = (op==LDW).
  - All three are driven only while the FSM is in REQ or ACCESS; otherwise 0.
- FSM states: IDLE, REQ, ACCESS, HOLD. Reset state is IDLE.
  - IDLE: if access, go to REQ; busy=1 combinationally in this cycle.
  - REQ: bus_req=1, busy=1. When bus_grnt, go to ACCESS; bus_as=1 for exactly the first ACCESS cycle (registered).
  - ACCESS: bus_req=1. When bus_rdy, latch bus_rd_data into rd_buf and drop busy combinationally that cycle; then go to HOLD if stall, else IDLE. Without bus_rdy, busy=1.
  - HOLD: busy=0; rd_buf is held; return to IDLE when stall==0.
  - While in HOLD, a new access is not started. The same EX/MEM entry must not re-trigger, so IDLE starts an access only when the previous access was not already completed for that entry. This is tracked by a done flag, set on bus_rdy and cleared when MEM/WB updates.
- flush in REQ: abort, deassert bus_req, return to IDLE.
- flush in ACCESS: wait for bus_rdy, discard the data, return to IDLE. The bus transaction is never abandoned mid-strobe.
- MEM/WB register, updated only when stall==0 and busy==0:
  - flush: bubble (all outputs 0, mem_gpr_we_=1).
  - miss: pass pc, en and br_flag; mem_exp_code=4; ctrl_op=NOP; gpr_we_=1; mem_out=0.
  - otherwise: pass all ex_* fields; mem_out = (op==LDW) ? load data : ex_out. Load data is bus_rd_data on the completion cycle, or rd_buf after HOLD.
  - STW with a valid access: pass fields unchanged (gpr_we_ as given).
- Reset: all outputs 0, except mem_gpr_we_=1 and busy=0; FSM to IDLE; done=0. Reset mid-transaction drops bus_req/bus_as immediately on the next edge.
- Latency:
  - Non-memory op: 1 cycle EX->MEM.
  - Memory op: 2 cycles (IDLE, REQ) + grant wait + ready wait, minimum 3 cycles with grant and ready each asserted on the first possible cycle.

Test Plan:
- Non-memory op (ex_en=1, op=NOP, ex_out=32'h1234) -> mem_out=32'h1234 next cycle; busy stays 0; bus_req never asserted.
- LDW at ex_out=32'h100; grant after 1 cycle, rdy 2 cycles later with rd_data=32'hDEADBEEF -> bus_addr=30'h40; bus_as pulses once; busy high until the rdy cycle; mem_out=32'hDEADBEEF, mem_gpr_we_=0.
- STW at ex_out=32'h104, data 32'hA5A5A5A5 -> bus_rw=0, bus_wr_data=32'hA5A5A5A5, bus_addr=30'h41; completes on rdy; mem_exp_code=0.
- LDW at ex_out=32'h102 -> no bus_req; mem_exp_code=4, mem_gpr_we_=1, mem_ctrl_op=0.
- LDW completes while stall=1 for 3 cycles -> FSM in HOLD; no second bus_req; after stall drops, mem_out=rd_buf value.
- reset asserted in ACCESS -> next edge: bus_req=0, bus_as=0, busy=0, mem_en=0, mem_gpr_we_=1; flush in REQ -> bus_req drops next cycle and MEM/WB becomes a bubble.
